// File: rtl/delay_arbiter.sv
// Round-robin arbiter that hands one shared millisecond-delay timer to four requesters.
// A requester is acknowledged when granted and receives a done pulse when its delay
// has expired; a zero delay completes without ever launching the timer.
module delay_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [63:0] req_delay_ms,
    output logic [3:0]  ack,
    output logic [3:0]  done,
    output logic [1:0]  grant_id,
    output logic        busy,
    output logic        tmr_step,
    output logic [15:0] tmr_delay_ms,
    input  logic        tmr_done,
    output logic        tmr_err
);

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWait,
        StComplete
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  last_grant_q, last_grant_d;
    logic [1:0]  grant_q, grant_d;
    logic [15:0] delay_q, delay_d;
    logic [3:0]  ack_q, ack_d;
    logic [3:0]  done_q, done_d;
    logic        step_q, step_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;

    logic [1:0]  winner;
    logic [1:0]  idx;
    logic        found;
    logic [15:0] win_delay;

    // Round-robin search: first requesting index after last_grant, wrapping modulo 4.
    always_comb begin
        winner = last_grant_q;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant_q + 2'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Delay slice belonging to the current round-robin winner.
    always_comb begin
        win_delay = req_delay_ms[{winner, 4'b0000} +: 16];
    end

    // Next-state and registered-output logic for the grant sequencer.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        delay_d      = delay_q;
        ack_d        = 4'b0000;
        done_d       = 4'b0000;
        step_d       = 1'b0;
        // Any timer completion that the sequencer is not waiting for is a protocol error.
        err_d        = err_q | (tmr_done && (state_q != StWait));

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = winner;
                    delay_d = win_delay;
                    ack_d   = 4'(4'b0001 << winner);
                    state_d = (win_delay != 16'd0) ? StLaunch : StComplete;
                end
            end
            StLaunch: begin
                step_d  = 1'b1;
                state_d = StWait;
            end
            StWait: begin
                if (tmr_done) begin
                    done_d  = 4'(4'b0001 << grant_q);
                    state_d = StComplete;
                end
            end
            StComplete: begin
                // Coming from WAIT the done pulse is already out; on the zero-delay path
                // it is issued here, one cycle after the ack, before returning to IDLE.
                if (done_q != 4'b0000) begin
                    last_grant_d = grant_q;
                    state_d      = StIdle;
                end else begin
                    done_d = 4'(4'b0001 << grant_q);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and output registers; reset favours requester 0 first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 2'd3;
            grant_q      <= 2'd0;
            delay_q      <= 16'd0;
            ack_q        <= 4'b0000;
            done_q       <= 4'b0000;
            step_q       <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            delay_q      <= delay_d;
            ack_q        <= ack_d;
            done_q       <= done_d;
            step_q       <= step_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    // Output wiring.
    always_comb begin
        ack          = ack_q;
        done         = done_q;
        grant_id     = grant_q;
        busy         = busy_q;
        tmr_step     = step_q;
        tmr_delay_ms = delay_q;
        tmr_err      = err_q;
    end

endmodule

// File: tb/tb_delay_arbiter.sv
// Self-checking bench for delay_arbiter: table of grant vectors plus hand-written
// round-robin, spurious-completion and reset-abort sequences, checked via a scoreboard.
module tb_delay_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] req_delay_ms;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic [1:0]  grant_id;
    logic        busy;
    logic        tmr_step;
    logic [15:0] tmr_delay_ms;
    logic        tmr_done;
    logic        tmr_err;

    delay_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_delay_ms (req_delay_ms),
        .ack          (ack),
        .done         (done),
        .grant_id     (grant_id),
        .busy         (busy),
        .tmr_step     (tmr_step),
        .tmr_delay_ms (tmr_delay_ms),
        .tmr_done     (tmr_done),
        .tmr_err      (tmr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  ack;
        logic [1:0]  grant;
        logic [15:0] delay;
    } exp_t;

    typedef struct {
        logic [3:0]  req;
        logic [63:0] delays;
        int          lat;
        logic [1:0]  grant;
    } vec_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   cur_valid = 1'b0;
    int   ack_cyc   = 0;
    int   tdone_cyc = 0;
    int   errors    = 0;
    int   checks    = 0;
    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not expected (t=%0t)", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] g, input logic [15:0] d);
        exp_t e;
        e.ack   = 4'(4'b0001 << g);
        e.grant = g;
        e.delay = d;
        exp_q.push_back(e);
    endtask

    // which: 0 ack, 1 tmr_step, 2 done, 3 idle (busy low)
    task automatic wait_for(input int which, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            case (which)
                0: ok = (ack != 4'b0000);
                1: ok = tmr_step;
                2: ok = (done != 4'b0000);
                default: ok = !busy;
            endcase
            if (ok) break;
            tick();
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: got no event expected event within 100 cycles", name);
        end
    endtask

    task automatic pulse_tmr_done();
        tmr_done = 1'b1;
        tick();
        tmr_done = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [63:0] d;
        logic [15:0] dl;
        int          g;
        d  = v.delays;
        g  = int'(v.grant);
        dl = d[g*16 +: 16];
        push_exp(v.grant, dl);
        req_delay_ms = v.delays;
        req          = v.req;
        wait_for(0, "ack");
        // Drop the request and scramble the delays: neither may affect the grant in flight.
        req          = 4'b0000;
        req_delay_ms = {$urandom, $urandom};
        if (dl != 16'd0) begin
            wait_for(1, "step");
            repeat (v.lat) tick();
            pulse_tmr_done();
        end
        wait_for(2, "done");
        wait_for(3, "idle");
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            cur_valid = 1'b0;
        end else begin
            if (tmr_done) tdone_cyc = cyc;
            if (ack != 4'b0000) begin
                check("ack_onehot", 64'($countones(ack)), 64'd1);
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_ack");
                end else begin
                    cur       = exp_q.pop_front();
                    cur_valid = 1'b1;
                    ack_cyc   = cyc;
                    check("ack", 64'(ack), 64'(cur.ack));
                    check("grant_id", 64'(grant_id), 64'(cur.grant));
                    check("busy_at_ack", 64'(busy), 64'd1);
                end
            end
            if (tmr_step) begin
                if (!cur_valid || cur.delay == 16'd0) begin
                    fail_now("unexpected_step");
                end else begin
                    check("step_latency", 64'(cyc), 64'(ack_cyc + 1));
                    check("tmr_delay_ms", 64'(tmr_delay_ms), 64'(cur.delay));
                end
            end
            if (done != 4'b0000) begin
                if (!cur_valid) begin
                    fail_now("unexpected_done");
                end else begin
                    check("done", 64'(done), 64'(cur.ack));
                    if (cur.delay == 16'd0) begin
                        check("done_latency_zero", 64'(cyc), 64'(ack_cyc + 1));
                    end else begin
                        check("done_latency", 64'(cyc), 64'(tdone_cyc + 1));
                        check("delay_hold", 64'(tmr_delay_ms), 64'(cur.delay));
                    end
                    cur_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        // {req, {d3,d2,d1,d0}, cycles step->tmr_done, expected grant}; starts with last_grant=3
        vecs[0] = '{4'b1001, {16'd6, 16'd0, 16'd0, 16'd3}, 2, 2'd0};
        vecs[1] = '{4'b1001, {16'd6, 16'd0, 16'd0, 16'd3}, 4, 2'd3};
        vecs[2] = '{4'b0001, {16'd0, 16'd0, 16'd0, 16'd5}, 20, 2'd0};
        vecs[3] = '{4'b0100, {16'd1, 16'd0, 16'd4, 16'd2}, 0, 2'd2};
        vecs[4] = '{4'b1110, {16'd2, 16'd7, 16'd8, 16'd0}, 1, 2'd3};
        vecs[5] = '{4'b0110, {16'd0, 16'd5, 16'd0, 16'd9}, 0, 2'd1};
        vecs[6] = '{4'b1111, {16'd11, 16'd10, 16'd12, 16'd13}, 5, 2'd2};

        rst          = 1'b1;
        req          = 4'b0000;
        req_delay_ms = 64'd0;
        tmr_done     = 1'b0;
        repeat (3) tick();
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_grant_id", 64'(grant_id), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_tmr_step", 64'(tmr_step), 64'd0);
        check("rst_tmr_delay_ms", 64'(tmr_delay_ms), 64'd0);
        check("rst_tmr_err", 64'(tmr_err), 64'd0);
        rst = 1'b0;
        tick();

        // Round robin with all requests held: grants 0,1,2,3,0.
        push_exp(2'd0, 16'd1);
        push_exp(2'd1, 16'd2);
        push_exp(2'd2, 16'd3);
        push_exp(2'd3, 16'd4);
        push_exp(2'd0, 16'd1);
        req_delay_ms = {16'd4, 16'd3, 16'd2, 16'd1};
        req          = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            wait_for(0, "rr_ack");
            if (r == 4) req = 4'b0000;
            wait_for(1, "rr_step");
            repeat (3) tick();
            pulse_tmr_done();
            wait_for(2, "rr_done");
        end
        wait_for(3, "rr_idle");

        // Fresh reset so the table starts from last_grant = 3.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            run_vec(v);
        end

        // Spurious tmr_done in IDLE: sticky error, no sequencing effect.
        tick();
        pulse_tmr_done();
        tick();
        check("spur_tmr_err", 64'(tmr_err), 64'd1);
        check("spur_busy", 64'(busy), 64'd0);
        repeat (5) tick();
        check("spur_tmr_err_sticky", 64'(tmr_err), 64'd1);
        check("spur_ack", 64'(ack), 64'd0);

        // Reset while requester 1 waits on the timer.
        push_exp(2'd1, 16'd7);
        req_delay_ms = {16'd0, 16'd0, 16'd7, 16'd0};
        req          = 4'b0010;
        wait_for(0, "abort_ack");
        req = 4'b0000;
        wait_for(1, "abort_step");
        tick();
        tick();
        check("abort_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_ack", 64'(ack), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_grant_id", 64'(grant_id), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_tmr_step", 64'(tmr_step), 64'd0);
        check("abort_tmr_delay_ms", 64'(tmr_delay_ms), 64'd0);
        check("abort_tmr_err", 64'(tmr_err), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        // Late completion of the aborted launch.
        pulse_tmr_done();
        tick();
        check("late_done_tmr_err", 64'(tmr_err), 64'd1);
        check("late_done_busy", 64'(busy), 64'd0);
        v = '{4'b0001, {16'd3, 16'd3, 16'd3, 16'd9}, 2, 2'd0};
        run_vec(v);

        repeat (3) tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/delay_arbiter.md
DELAY_ARBITER -- requirements
Module: delay_arbiter

Interface
REQ-001 Parameter: none; requester count SHALL be fixed at 4, delay width fixed at 16 bits (milliseconds).
REQ-002 clk  input  1  single system clock; all state SHALL update on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  level request, bit i = requester i.
REQ-005 req_delay_ms  input  64  requester i delay in ms at bits [16*i+15:16*i].
REQ-006 ack  output  4  one-cycle pulse, requester i's request was accepted.
REQ-007 done  output  4  one-cycle pulse, requester i's delay has completed.
REQ-008 grant_id  output  2  index of requester currently owning the timer.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 tmr_step  output  1  launch strobe to the shared ms-delay timer (timer triggers on rising edge).
REQ-011 tmr_delay_ms  output  16  delay value presented to the timer.
REQ-012 tmr_done  input  1  one-cycle completion pulse from the timer.
REQ-013 tmr_err  output  1  sticky flag, tmr_done seen outside WAIT.

Function
REQ-014 FSM states SHALL be IDLE, LAUNCH, WAIT, COMPLETE; all outputs registered.
REQ-015 IDLE: if req != 0, winner SHALL be first set bit searching from (last_grant+1) mod 4 upward with wrap; no request -> stay IDLE.
REQ-016 On accept: grant_id <= winner; delay latched from winner's slice; ack[winner] high in the next cycle only.
REQ-017 On accept with latched delay != 0 -> LAUNCH; with delay == 0 -> COMPLETE directly, timer never launched.
REQ-018 LAUNCH: tmr_step SHALL be high for exactly this one cycle; next state WAIT.
REQ-019 tmr_delay_ms SHALL hold the latched delay from LAUNCH through WAIT, stable while tmr_step high.
REQ-020 WAIT: stay until tmr_done == 1, then -> COMPLETE; no timeout.
REQ-021 COMPLETE: done[grant_id] high for this one cycle; last_grant <= grant_id; next state IDLE.
REQ-022 At most one ack bit and one done bit SHALL be high in any cycle.
REQ-023 tmr_step SHALL be low for at least one cycle between consecutive launches (IDLE cycle guarantees this).
REQ-024 req and req_delay_ms are sampled only in IDLE; changes at other times SHALL be ignored.
REQ-025 Requester SHALL drop req after ack; req still high on return to IDLE counts as a new request.
REQ-026 tmr_done while state != WAIT SHALL be ignored for sequencing and SHALL set tmr_err.
REQ-027 Latency (non-zero delay): req seen at edge N -> ack cycle N+1, tmr_step cycle N+2; tmr_done at M -> done cycle M+1; IDLE at M+2.
REQ-028 Latency (zero delay): req at edge N -> ack cycle N+1, done cycle N+2, IDLE cycle N+3.

Reset
REQ-029 rst high SHALL immediately force: state IDLE, ack 0, done 0, grant_id 0, busy 0, tmr_step 0, tmr_delay_ms 0, tmr_err 0, last_grant 3 (requester 0 highest priority first).
REQ-030 Reset mid-operation SHALL abort the grant with no done pulse; a later tmr_done from the aborted launch SHALL be ignored and SHALL set tmr_err.

Verification
REQ-031 Single request: req=0001, delay0=5, tmr_done pulsed 20 cycles after tmr_step -> ack=0001 one cycle, tmr_step one cycle with tmr_delay_ms=5, done=0001 one cycle after tmr_done.
REQ-032 Round robin: req=1111 held, tmr_done returned each WAIT -> grant order 0,1,2,3,0; each ack bit once per round.
REQ-033 Zero delay: req=0100, delay2=0 -> ack=0100 then done=0100 next cycle, tmr_step never high.
REQ-034 Wrap priority: last_grant=3, req=1001 -> requester 0 granted; then req=1001 again -> requester 3 granted.
REQ-035 Spurious done: tmr_done pulsed in IDLE -> no done pulse, state IDLE, tmr_err=1 until rst.
REQ-036 Reset in WAIT: grant to requester 1 then rst pulse -> all outputs 0 immediately, no done; subsequent req=0001 granted normally.
